// File: rtl/avalon_host_pkg.sv
// Shared state encoding and bus constants for the Avalon host word-copy engine.
package avalon_host_pkg;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } copy_state_t;

endpackage

// File: rtl/avalon_if.sv
// Avalon-MM bundle; the host modport is the view the copy engine drives.
interface avalon_if #(
    parameter int BURSTCOUNT_W = 4
);

    logic                    clk;
    logic                    reset;
    logic [31:0]             address;
    logic                    read;
    logic                    write;
    logic [31:0]             writedata;
    logic [3:0]              byteenable;
    logic [BURSTCOUNT_W-1:0] burstcount;
    logic [31:0]             readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport host (
        input  clk,
        input  reset,
        input  readdata,
        input  readdatavalid,
        input  waitrequest,
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        output burstcount
    );

endinterface

// File: rtl/avalon_host_checksum.sv
// Running 32-bit sum of the words read by the copy engine; cleared when a copy is accepted.
module avalon_host_checksum
    import avalon_host_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        add_en,
    input  logic [31:0] data,
    output logic [31:0] sum
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/avalon_host_copy.sv
// Single-word-at-a-time Avalon-MM copy engine: read a word, write it, repeat len times.
// Define AVALON_HOST_CHECKSUM_EN to build the running checksum of copied words.
module avalon_host_copy
    import avalon_host_pkg::*;
#(
    parameter int LEN_W        = 16,
    parameter int BURSTCOUNT_W = 4
) (
    avalon_if.host            avalon_h,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam logic [2:0]  S_IDLE    = 3'(IDLE);
    localparam logic [2:0]  S_RD_REQ  = 3'(RD_REQ);
    localparam logic [2:0]  S_RD_WAIT = 3'(RD_WAIT);
    localparam logic [2:0]  S_WR_REQ  = 3'(WR_REQ);
    localparam logic [2:0]  S_DONE    = 3'(DONE);
    localparam logic [31:0] STEP      = 32'(BYTES_PER_WORD);

    logic [2:0]       state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] remaining;

    assign avalon_h.byteenable = BYTEENABLE_ALL;
    assign avalon_h.burstcount = BURSTCOUNT_W'(1);

    // Requests are raised on the transition into RD_REQ/WR_REQ so read, write and
    // address come straight from flops and stay put until the agent accepts them.
    always_ff @(posedge avalon_h.clk) begin
        if (avalon_h.reset) begin
            state              <= S_IDLE;
            src_ptr            <= '0;
            dst_ptr            <= '0;
            remaining          <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            avalon_h.read      <= 1'b0;
            avalon_h.write     <= 1'b0;
            avalon_h.address   <= '0;
            avalon_h.writedata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            state <= S_DONE;
                        end else begin
                            state            <= S_RD_REQ;
                            avalon_h.read    <= 1'b1;
                            avalon_h.address <= src_addr;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (!avalon_h.waitrequest) begin
                        avalon_h.read <= 1'b0;
                        state         <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (avalon_h.readdatavalid) begin
                        avalon_h.writedata <= avalon_h.readdata;
                        avalon_h.write     <= 1'b1;
                        avalon_h.address   <= dst_ptr;
                        state              <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (!avalon_h.waitrequest) begin
                        avalon_h.write <= 1'b0;
                        src_ptr        <= src_ptr + STEP;
                        dst_ptr        <= dst_ptr + STEP;
                        remaining      <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= S_DONE;
                        end else begin
                            state            <= S_RD_REQ;
                            avalon_h.read    <= 1'b1;
                            avalon_h.address <= src_ptr + STEP;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AVALON_HOST_CHECKSUM_EN
    logic sum_clear;
    logic sum_add;

    assign sum_clear = (state == S_IDLE) && start;
    assign sum_add   = (state == S_RD_WAIT) && avalon_h.readdatavalid;

    avalon_host_checksum u_checksum (
        .clk    (avalon_h.clk),
        .reset  (avalon_h.reset),
        .clear  (sum_clear),
        .add_en (sum_add),
        .data   (avalon_h.readdata),
        .sum    (checksum)
    );
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_avalon_host_copy.sv
// Directed bench for avalon_host_copy with a small Avalon memory agent and protocol monitors.
module tb_avalon_host_copy;

`ifdef AVALON_HOST_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic        init_mem;
    int          wait_cfg;
    int          rdv_cfg;

    int n_compared = 0;
    int n_mismatch = 0;

    avalon_if #(.BURSTCOUNT_W(4)) bus ();

    avalon_host_copy #(
        .LEN_W        (16),
        .BURSTCOUNT_W (4)
    ) dut (
        .avalon_h (bus),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    // Agent state: word memory, stall counter and a single delayed read-data slot
    logic [31:0] mem [256];
    int          stall_cnt = 0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    logic        rdv_q = 1'b0;
    logic [31:0] rdata_q = '0;
    logic        waitreq;

    int n_reads = 0;
    int n_writes = 0;
    int n_done = 0;
    int n_stall = 0;
    int viol_rw = 0;
    int viol_stable = 0;
    int viol_outstanding = 0;
    int viol_early = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] prev_rd_addr = '0;

    logic        prev_read = 1'b0;
    logic        prev_write = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    assign bus.clk           = clk;
    assign bus.reset         = rst;
    assign waitreq           = (bus.read || bus.write) && (stall_cnt < wait_cfg);
    assign bus.waitrequest   = waitreq;
    assign bus.readdatavalid = rdv_q;
    assign bus.readdata      = rdata_q;

    // Memory agent plus protocol monitors, all sampled on the rising edge
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[0]   <= 32'd11;
            mem[1]   <= 32'd22;
            mem[2]   <= 32'd33;
            mem[3]   <= 32'd44;
            mem[255] <= 32'h1234_5678;
        end else if (bus.write && !waitreq) begin
            mem[bus.address[9:2]] <= bus.writedata;
            n_writes <= n_writes + 1;
        end

        if (bus.read || bus.write) stall_cnt <= waitreq ? stall_cnt + 1 : 0;
        if ((bus.read || bus.write) && waitreq) n_stall <= n_stall + 1;

        rdv_q <= 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                rdv_q   <= 1'b1;
                rdata_q <= pend_data;
                pend    <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
        if (bus.read && !waitreq) begin
            if (pend || rdv_q) viol_outstanding <= viol_outstanding + 1;
            pend         <= 1'b1;
            pend_cnt     <= rdv_cfg;
            pend_data    <= mem[bus.address[9:2]];
            n_reads      <= n_reads + 1;
            prev_rd_addr <= last_rd_addr;
            last_rd_addr <= bus.address;
        end

        if (bus.write && pend) viol_early <= viol_early + 1;
        if (bus.read && bus.write) viol_rw <= viol_rw + 1;
        if (done) n_done <= n_done + 1;

        if (prev_read && prev_wait && !(bus.read && !bus.write && bus.address == prev_addr))
            viol_stable <= viol_stable + 1;
        if (prev_write && prev_wait &&
            !(bus.write && !bus.read && bus.address == prev_addr && bus.writedata == prev_wdata))
            viol_stable <= viol_stable + 1;
        prev_read  <= bus.read;
        prev_write <= bus.write;
        prev_wait  <= waitreq;
        prev_addr  <= bus.address;
        prev_wdata <= bus.writedata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_read"},      32'(bus.read),      32'd0);
        checkOutput({tag, "_write"},     32'(bus.write),     32'd0);
        checkOutput({tag, "_busy"},      32'(busy),          32'd0);
        checkOutput({tag, "_done"},      32'(done),          32'd0);
        checkOutput({tag, "_address"},   bus.address,        32'd0);
        checkOutput({tag, "_writedata"}, bus.writedata,      32'd0);
        checkOutput({tag, "_checksum"},  checksum,           32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_rd, base_wr, base_dn, base_st, n;

        rst      = 1'b1;
        init_mem = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        wait_cfg = 0;
        rdv_cfg  = 0;
        repeat (3) @(negedge clk);
        init_mem = 1'b0;
        checkResetOutputs("rst");
        checkOutput("rst_byteenable", 32'(bus.byteenable), 32'hF);
        checkOutput("rst_burstcount", 32'(bus.burstcount), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Basic four-word copy
        base_rd = n_reads; base_wr = n_writes; base_dn = n_done;
        applyStimulus(32'h0, 32'h100, 16'd4);
        waitDone("t1", 300);
        repeat (2) @(negedge clk);
        checkOutput("t1_w0", mem[8'h40], 32'd11);
        checkOutput("t1_w1", mem[8'h41], 32'd22);
        checkOutput("t1_w2", mem[8'h42], 32'd33);
        checkOutput("t1_w3", mem[8'h43], 32'd44);
        checkOutput("t1_done_pulses", 32'(n_done - base_dn), 32'd1);
        checkOutput("t1_reads", 32'(n_reads - base_rd), 32'd4);
        checkOutput("t1_writes", 32'(n_writes - base_wr), 32'd4);
        checkOutput("t1_checksum", checksum, CK_EN ? 32'd110 : 32'd0);
        checkOutput("t1_busy_after", 32'(busy), 32'd0);

        // Zero-length copy, then a start in the same cycle done is high
        base_rd = n_reads; base_wr = n_writes;
        @(negedge clk);
        start = 1'b1; src_addr = 32'h0; dst_addr = 32'h0; len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t2_busy_c1", 32'(busy), 32'd1);
        checkOutput("t2_done_c1", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("t2_busy_c2", 32'(busy), 32'd0);
        checkOutput("t2_done_c2", 32'(done), 32'd1);
        checkOutput("t2_checksum_cleared", checksum, 32'd0);
        start = 1'b1; src_addr = 32'h8; dst_addr = 32'h140; len = 16'd1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t2_restart_busy", 32'(busy), 32'd1);
        checkOutput("t2_restart_done", 32'(done), 32'd0);
        waitDone("t2", 100);
        @(negedge clk);
        checkOutput("t2_word", mem[8'h50], 32'd33);
        checkOutput("t2_reads", 32'(n_reads - base_rd), 32'd1);
        checkOutput("t2_writes", 32'(n_writes - base_wr), 32'd1);
        checkOutput("t2_checksum", checksum, CK_EN ? 32'd33 : 32'd0);

        // Three stall cycles on every request
        wait_cfg = 3;
        base_st = n_stall;
        applyStimulus(32'h0, 32'h180, 16'd4);
        waitDone("t3", 600);
        @(negedge clk);
        wait_cfg = 0;
        checkOutput("t3_w0", mem[8'h60], 32'd11);
        checkOutput("t3_w1", mem[8'h61], 32'd22);
        checkOutput("t3_w2", mem[8'h62], 32'd33);
        checkOutput("t3_w3", mem[8'h63], 32'd44);
        checkOutput("t3_stall_cycles", 32'(n_stall - base_st), 32'd24);
        checkOutput("t3_stable", 32'(viol_stable), 32'd0);
        checkOutput("t3_checksum", checksum, CK_EN ? 32'd110 : 32'd0);

        // Slow read data
        rdv_cfg = 5;
        applyStimulus(32'h0, 32'h200, 16'd4);
        waitDone("t4", 600);
        @(negedge clk);
        checkOutput("t4_w0", mem[8'h80], 32'd11);
        checkOutput("t4_w3", mem[8'h83], 32'd44);
        checkOutput("t4_early_write", 32'(viol_early), 32'd0);
        checkOutput("t4_outstanding", 32'(viol_outstanding), 32'd0);
        checkOutput("t4_rd_and_wr", 32'(viol_rw), 32'd0);

        // Reset after two words, with the third read still in flight
        base_rd = n_reads; base_wr = n_writes;
        applyStimulus(32'h0, 32'h280, 16'd4);
        n = 0;
        while (!((n_writes - base_wr) >= 2 && (n_reads - base_rd) >= 3) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_reached_mid", 32'(n_reads - base_rd), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("t5_rst");
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("t5_idle_busy", 32'(busy), 32'd0);
        checkOutput("t5_writes_after_rst", 32'(n_writes - base_wr), 32'd2);
        checkOutput("t5_w1_kept", mem[8'hA1], 32'd22);
        checkOutput("t5_w2_untouched", mem[8'hA2], 32'd0);
        checkOutput("t5_write_idle", 32'(bus.write), 32'd0);
        rdv_cfg = 0;
        applyStimulus(32'h0, 32'h300, 16'd4);
        waitDone("t5", 300);
        @(negedge clk);
        checkOutput("t5_new_w0", mem[8'hC0], 32'd11);
        checkOutput("t5_new_w3", mem[8'hC3], 32'd44);
        checkOutput("t5_checksum", checksum, CK_EN ? 32'd110 : 32'd0);

        // Address wrap and a start pulse while busy
        base_wr = n_writes; base_dn = n_done;
        applyStimulus(32'hFFFF_FFFC, 32'h340, 16'd2);
        applyStimulus(32'h40, 32'h3C0, 16'd1);
        waitDone("t6", 300);
        repeat (10) @(negedge clk);
        checkOutput("t6_first_rd_addr", prev_rd_addr, 32'hFFFF_FFFC);
        checkOutput("t6_second_rd_addr", last_rd_addr, 32'h0);
        checkOutput("t6_w0", mem[8'hD0], 32'h1234_5678);
        checkOutput("t6_w1", mem[8'hD1], 32'd11);
        checkOutput("t6_ignored_dst", mem[8'hF0], 32'd0);
        checkOutput("t6_writes", 32'(n_writes - base_wr), 32'd2);
        checkOutput("t6_done_pulses", 32'(n_done - base_dn), 32'd1);
        checkOutput("t6_checksum", checksum, CK_EN ? 32'h1234_5683 : 32'd0);
        checkOutput("t6_rd_and_wr", 32'(viol_rw), 32'd0);
        checkOutput("t6_outstanding", 32'(viol_outstanding), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
